// File: rtl/i2s_audio_tx.sv
// I2S transmitter: one free-running frame counter drives MCLK/LRCK/SCK/SDIN; the stereo pair is latched at frame end.
// Optional build macro AUDIO_MUTE_EN adds a mute input that zeroes the captured pair.
module i2s_audio_tx #(
    parameter int MCLK_LOG2 = 1,
    parameter int SCK_LOG2  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
`ifdef AUDIO_MUTE_EN
    input  logic        mute,
`endif
    output logic        sample_req,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam int W = SCK_LOG2 + 7;

    logic [W-1:0] cnt_q, cnt_d;
    logic [15:0]  hold_l_q, hold_l_d;
    logic [15:0]  hold_r_q, hold_r_d;
    logic         capture;
    logic [5:0]   slot_d;
    logic [3:0]   l_idx, r_idx;
    logic         sdin_d;

    logic sample_req_q, mclk_q, lrck_q, sck_q, sdin_q;

    assign capture = (cnt_q == {W{1'b1}});
    assign cnt_d   = cnt_q + {{(W-1){1'b0}}, 1'b1};
    assign slot_d  = cnt_d[W-1:SCK_LOG2+1];

    // Bit positions are only meaningful inside the data slots; the range tests below gate them.
    assign l_idx = 4'(6'd16 - slot_d);
    assign r_idx = 4'(6'd49 - slot_d);

    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (capture) begin
`ifdef AUDIO_MUTE_EN
            hold_l_d = mute ? 16'h0000 : audio_left;
            hold_r_d = mute ? 16'h0000 : audio_right;
`else
            hold_l_d = audio_left;
            hold_r_d = audio_right;
`endif
        end
    end

    // Outputs are registered from the next count, so each one matches the count it is shown with.
    always_comb begin
        sdin_d = 1'b0;
        if (slot_d >= 6'd1 && slot_d <= 6'd16) begin
            sdin_d = hold_l_d[l_idx];
        end else if (slot_d >= 6'd34 && slot_d <= 6'd49) begin
            sdin_d = hold_r_d[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            sample_req_q <= 1'b0;
            mclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            sck_q        <= 1'b0;
            sdin_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            sample_req_q <= capture;
            mclk_q       <= cnt_d[MCLK_LOG2];
            lrck_q       <= slot_d[5];
            sck_q        <= cnt_d[SCK_LOG2];
            sdin_q       <= sdin_d;
        end
    end

    assign sample_req = sample_req_q;
    assign audio_mclk = mclk_q;
    assign audio_lrck = lrck_q;
    assign audio_sck  = sck_q;
    assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: per-cycle reference model plus directed frame-pattern checks.
module tb_i2s_audio_tx;

    localparam int MCLK_LOG2 = 1;
    localparam int SCK_LOG2  = 3;
    localparam int W         = SCK_LOG2 + 7;
    localparam int FRAME     = 1 << W;
    localparam int SLOT_CYC  = 1 << (SCK_LOG2 + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] audio_left  = 16'h0000;
    logic [15:0] audio_right = 16'h0000;
`ifdef AUDIO_MUTE_EN
    logic        mute = 1'b0;
`endif
    logic sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin;

    i2s_audio_tx #(.MCLK_LOG2(MCLK_LOG2), .SCK_LOG2(SCK_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .audio_left (audio_left),
        .audio_right(audio_right),
`ifdef AUDIO_MUTE_EN
        .mute       (mute),
`endif
        .sample_req (sample_req),
        .audio_mclk (audio_mclk),
        .audio_lrck (audio_lrck),
        .audio_sck  (audio_sck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          m_cnt    = 0;
    logic [15:0] m_hl     = 16'h0000;
    logic [15:0] m_hr     = 16'h0000;
    logic        m_req    = 1'b0;
    int          frames   = 0;
    logic        prev_sck  = 1'b0;
    logic        prev_sdin = 1'b0;
    bit          rand_inputs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Serial bit expected in a given frame position, straight from the slot map.
    function automatic logic exp_sdin(input int c, input logic [15:0] hl, input logic [15:0] hr);
        int s;
        s = c / SLOT_CYC;
        if (s >= 1 && s <= 16) return hl[16 - s];
        if (s >= 34 && s <= 49) return hr[49 - s];
        return 1'b0;
    endfunction

    task automatic tick();
        logic        rst_s;
        logic [15:0] l_s, r_s;
        logic        mute_s;
        rst_s  = rst;
        l_s    = audio_left;
        r_s    = audio_right;
        mute_s = 1'b0;
`ifdef AUDIO_MUTE_EN
        mute_s = mute;
`endif
        @(posedge clk);
        #1;
        if (rst_s) begin
            m_cnt = 0;
            m_hl  = 16'h0000;
            m_hr  = 16'h0000;
            m_req = 1'b0;
        end else begin
            m_req = (m_cnt == FRAME - 1);
            if (m_req) begin
                m_hl = mute_s ? 16'h0000 : l_s;
                m_hr = mute_s ? 16'h0000 : r_s;
            end
            m_cnt = (m_cnt + 1) % FRAME;
        end
        chk("mclk", 64'(audio_mclk), 64'((m_cnt >> MCLK_LOG2) & 1));
        chk("sck",  64'(audio_sck),  64'((m_cnt >> SCK_LOG2) & 1));
        chk("lrck", 64'(audio_lrck), 64'((m_cnt / SLOT_CYC) >= 32));
        chk("sdin", 64'(audio_sdin), 64'(exp_sdin(m_cnt, m_hl, m_hr)));
        chk("sample_req", 64'(sample_req), 64'(m_req));
        if (!rst_s && audio_sdin !== prev_sdin)
            chk("sdin_on_sck_fall", 64'({prev_sck, audio_sck}), 64'(2'b10));
        prev_sck  = audio_sck;
        prev_sdin = audio_sdin;
        if (m_req) begin
            frames++;
            $display("frame %0d latched L=%h R=%h", frames, m_hl, m_hr);
        end
        if (rand_inputs) begin
            audio_left  = 16'($urandom);
            audio_right = 16'($urandom);
        end
    endtask

    // Runs one full frame from cnt==0, sampling SDIN at each SCK rising edge; optional mid-frame left change.
    task automatic collect(output logic [63:0] bits, output int reqs,
                           input int change_at, input logic [15:0] new_left);
        bits = '0;
        reqs = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (m_cnt % SLOT_CYC == SLOT_CYC / 2) bits[m_cnt / SLOT_CYC] = audio_sdin;
            if (m_cnt == change_at) audio_left = new_left;
            tick();
            if (sample_req) reqs++;
        end
    endtask

    initial begin
        logic [63:0] bits;
        int          reqs;
        int          first;

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_outputs", 64'({sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin}), 64'd0);
        end
        rst = 1'b0;

        first = -1;
        for (int i = 1; i <= 2 * FRAME && first < 0; i++) begin
            tick();
            if (sample_req) first = i;
        end
        chk("first_req_latency", 64'(first), 64'(FRAME));

        audio_left  = 16'hFF00;
        audio_right = 16'h0000;
        collect(bits, reqs, -1, 16'h0);
        chk("zero_frame_after_reset", bits, 64'h0);
        collect(bits, reqs, -1, 16'h0);
        chk("left_ff00_frame", bits, 64'h0000_0000_0000_01FE);
        chk("left_req_count", 64'(reqs), 64'd1);

        audio_left  = 16'h0000;
        audio_right = 16'h8001;
        collect(bits, reqs, -1, 16'h0);
        chk("left_ff00_repeat", bits, 64'h0000_0000_0000_01FE);
        collect(bits, reqs, -1, 16'h0);
        chk("right_8001_frame", bits, 64'h0002_0004_0000_0000);

        audio_left  = 16'hAAAA;
        audio_right = 16'h0000;
        collect(bits, reqs, -1, 16'h0);
        chk("right_8001_repeat", bits, 64'h0002_0004_0000_0000);
        collect(bits, reqs, 300, 16'h5555);
        chk("midframe_keeps_aaaa", bits, 64'h0000_0000_0000_AAAA);
        chk("midframe_req_count", 64'(reqs), 64'd1);
        collect(bits, reqs, -1, 16'h0);
        chk("next_frame_5555", bits, 64'h0000_0000_0001_5554);

        while (m_cnt != 10 * SLOT_CYC) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_outputs", 64'({sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin}), 64'd0);
        collect(bits, reqs, -1, 16'h0);
        chk("post_reset_zero_frame", bits, 64'h0);
        chk("post_reset_req_at_1024", 64'({reqs, sample_req}), 64'({32'd1, 1'b1}));

        rand_inputs = 1'b1;
        for (int f = 0; f < 6; f++) begin
            collect(bits, reqs, -1, 16'h0);
            chk("random_req_count", 64'(reqs), 64'd1);
        end
        rand_inputs = 1'b0;

`ifdef AUDIO_MUTE_EN
        audio_left  = 16'hFFFF;
        audio_right = 16'h0000;
        mute        = 1'b1;
        collect(bits, reqs, -1, 16'h0);
        collect(bits, reqs, -1, 16'h0);
        chk("muted_frame", bits, 64'h0);
        chk("muted_req_count", 64'(reqs), 64'd1);
        mute = 1'b0;
        collect(bits, reqs, -1, 16'h0);
        collect(bits, reqs, -1, 16'h0);
        chk("unmuted_ffff", bits, 64'h0000_0000_0001_FFFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- I2S transmitter that consumes the 16-bit stereo sample words produced by the tone and buzzer generators (audio_left/audio_right).
- Serializes each word pair onto the on-board audio DAC pins: MCLK, LRCK, SCK, SDIN.
- Sits between the sound generator and the top-level audio pins.
- Requests a new sample pair once per frame with a one-cycle pulse.

Parameters:
- MCLK_LOG2, 1: MCLK half-period = 2^MCLK_LOG2 clk cycles (default MCLK = clk/4). Must be < SCK_LOG2.
- SCK_LOG2, 3: SCK half-period = 2^SCK_LOG2 clk cycles (default SCK = clk/16).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- audio_left  input  16  left sample, two's complement, MSB first on the wire
- audio_right  input  16  right sample
- sample_req  output  1  one-cycle pulse; the sample pair was latched this frame
- audio_mclk  output  1  master clock to DAC
- audio_lrck  output  1  word select: 0 = left, 1 = right
- audio_sck  output  1  serial bit clock
- audio_sdin  output  1  serial data

Behaviour:
- One free-running frame counter cnt, width W = SCK_LOG2+7, counts 0..2^W-1 and wraps. Default W = 10, frame = 1024 clk.
- slot = cnt[W-1:SCK_LOG2+1], range 0..63. One slot = one SCK period.
- All outputs are registered; each output equals its function of the current cnt, so there are no combinational glitches:
  - audio_mclk = cnt[MCLK_LOG2]
  - audio_sck = cnt[SCK_LOG2], so SCK is low in the first half of each slot.
  - audio_lrck = slot[5]
- Capture: on the cycle with cnt == 2^W-1, hold_l <= audio_left and hold_r <= audio_right. sample_req = 1 in the following cycle (cnt == 0) only.
- Inputs are sampled only at capture; changes elsewhere in the frame have no effect on the current frame.
- SDIN uses I2S format with a one-SCK delay after the LRCK edge:
  - slot 0 -> 0
  - slots 1..16 -> hold_l[16-slot]
  - slots 17..33 -> 0
  - slots 34..49 -> hold_r[49-slot]
  - slots 50..63 -> 0
  - SDIN therefore changes only on SCK falling edges (slot boundaries) and is stable across each SCK rising edge.
- Reset state: cnt = 0, hold_l = hold_r = 0, all outputs 0. The first frame after reset transmits zeros.
- The first sample_req after reset occurs 2^W cycles after reset deassertion, not immediately.
- Reset asserted mid-frame: everything returns to the reset state on the next clk edge, and the partial frame is abandoned. No sample_req is issued for the abandoned frame.
- Counter wrap is the only frame boundary; no back-pressure. Upstream must present valid data at all times, or update in response to sample_req.

Optional Feature:
- Macro AUDIO_MUTE_EN.
- Defined:
  - Adds port mute (input, 1 bit).
  - mute is sampled at capture; if 1, hold_l and hold_r load 16'h0000 instead of the inputs.
  - sample_req still pulses, and clocks keep running.
- Undefined: no mute port; capture always loads the inputs.

Test Plan:
- Reset and clocks: hold rst 5 cycles, release -> all outputs 0 during reset; audio_mclk toggles every 2 clk, audio_sck every 8 clk, audio_lrck every 512 clk. No sample_req before cycle 1024 after release.
- Left pattern: audio_left = 16'hFF00, audio_right = 0, run 2 frames -> second frame: SDIN = 1 in slots 1..8 and 0 in slots 9..16; SDIN = 0 throughout LRCK high.
- Right pattern: audio_right = 16'h8001, audio_left = 0 -> SDIN = 1 in slots 34 and 49 only; every SDIN transition coincides with an SCK falling edge.
- Input change mid-frame: switch audio_left from 16'hAAAA to 16'h5555 at cnt = 300 -> current frame still shows 1010... from slot 1. The next frame shows 0101...; sample_req is high exactly once per 1024 cycles, at cnt == 0.
- Mid-frame reset: assert rst at slot 10 for 1 cycle -> next cycle all outputs 0 and cnt = 0. The following frame transmits zeros, and capture occurs 1024 cycles later.
- With AUDIO_MUTE_EN: mute = 1 at capture, audio_left = 16'hFFFF -> next frame SDIN stays 0 while sample_req still pulses. Deassert mute -> the following frame shows 16 ones in slots 1..16.
